xgmii_rx_frame_checker: RTL and testbench
=========================================

// Module: xgmii_rx_frame_checker
// PURPOSE
//  Checks and counts received 10GBASE-R frames on one 64-bit XGMII RX lane set, in the clk156 domain.
//  Sits directly downstream of xgmiisync (consumes the aligned xgmii_rxd/rxc) and provides the receive
//  side for the loopback/generator test path that drives xgmii0_txd/txc.
//  Per frame it validates preamble/SFD, length, control-character errors and FCS (CRC-32).
//  It exposes good/bad counters, last frame length and a per-frame result pulse for LEDs/debug.
// PARAMETERS
//  MIN_LEN   64    minimum frame bytes (DA..FCS inclusive); shorter = runt = bad
//  MAX_LEN   1518  maximum frame bytes; longer = giant = bad (bytes still consumed to terminate)
//  CNT_W     32    width of good/bad frame counters
// PORTS
//  clk156         in   1      156.25 MHz XGMII clock
//  sys_rst_n      in   1      asynchronous, active-low reset
//  xgmii_rxd      in   64     RX data, lane k = bits [8k+7:8k], lane 0 first on wire
//  xgmii_rxc      in   8      RX control, bit k qualifies lane k
//  clr_cnt        in   1      synchronous clear of good_cnt/bad_cnt (wins over same-cycle increment)
//  frame_done     out  1      1-cycle pulse: one frame result available
//  frame_good     out  1      result of last frame (held until next frame_done)
//  frame_len      out  16     byte count of last frame, DA..FCS (held; saturates at 16'hFFFF)
//  good_cnt       out  CNT_W  good frames, wraps modulo 2^CNT_W
//  bad_cnt        out  CNT_W  bad frames, wraps modulo 2^CNT_W
//  err_flags      out  4      last-frame cause {fcs, len, ctrl, preamble}; held with frame_good
// BEHAVIOUR
//  - Reset: all outputs 0; FSM = IDLE; CRC register = 32'hFFFFFFFF.
//  - Start beat: rxc==8'h01 and lane0==8'hFB. Lanes1-6 must be 8'h55 and lane7 8'hD5, else preamble error.
//  - FSM IDLE: start beat -> DATA (CRC init 32'hFFFFFFFF, len=0). Anything else is ignored (idles, faults).
//  - FSM DATA, per beat: the lowest lane k with rxc[k]=1 ends the data. If lane k==8'hFD (terminate),
//    lanes <k are data, the frame closes, and the FSM returns to IDLE. k may be 0, meaning no data in
//    that beat. If rxc==0, all 8 lanes are data.
//  - DATA: control lane not FD (e.g. FE error, 07 idle) -> ctrl error, frame closes, FSM -> IDLE.
//  - DATA: a start beat -> close current frame as ctrl error (bad), and open a new frame from that beat.
//  - Length: add the data-byte count of each beat. len<MIN_LEN or len>MAX_LEN sets len error.
//  - FCS: CRC-32 IEEE 802.3, reflected, poly 32'hEDB88320, over all data bytes including FCS.
//    Good iff the final register (not inverted) == 32'hDEBB20E3; else fcs error.
//  - frame_good = no error flag set.
//  - Latency: terminate/close in beat T -> frame_done, frame_good, frame_len, err_flags and counter
//    updates all occur in cycle T+2 (one CRC pipeline stage + one result register).
//  - A frame closing every cycle must be sustained. Back-to-back terminate/start at minimum IFG is
//    handled with no lost frames.
//  - clr_cnt in the same cycle as frame_done: counters become 0; frame_good/frame_len still update.
//  - Reset asserted mid-frame: the frame is discarded, no pulse, and counters read 0.
//  - Ordered sets (lane0=8'h9C with rxc[0]) in IDLE are ignored and not counted.
// STRUCTURE
//  - Package xgmii_pkg: XGMII_IDLE=8'h07, XGMII_START=8'hFB, XGMII_TERM=8'hFD, XGMII_ERR=8'hFE,
//    PREAMBLE=8'h55, SFD=8'hD5, CRC_POLY, CRC_INIT, CRC_RESIDUE, and the FSM state enum {IDLE, DATA}.
//  - Sub-module crc32_d64: combinational next-CRC over 64-bit data with a byte count (0..8) input.
//    Reused later by the TX generator for FCS insertion.
//  - Top holds the FSM, length accumulator, CRC pipeline register, result register and counters.
// TESTING
//  1 Min frame: 64-byte broadcast UDP frame with correct FCS, terminate in lane 0 of the next beat
//    -> frame_done at T+2, frame_good=1, frame_len=64, good_cnt=1.
//  2 Same frame with 1 FCS bit flipped -> frame_good=0, err_flags=4'b1000, bad_cnt=1, good_cnt unchanged.
//  3 Terminate swept through lanes 0..7 (frame lengths 64..71), correct FCS -> 8 good frames with
//    frame_len 64..71.
//  4 60-byte runt and 1519-byte giant, both with valid FCS -> bad_cnt=2, err_flags=4'b0100 for each.
//  5 8'hFE in lane 3 mid-frame -> ctrl error. Start beat mid-frame -> 1 bad frame, then the new frame
//    is counted good.
//  6 100 back-to-back 64-byte frames at 12-byte IFG, with clr_cnt coinciding with frame_done #50
//    -> good_cnt=50 at end. sys_rst_n dropped mid-frame -> all outputs 0, no spurious frame_done.

Source files
------------

// File: rtl/xgmii_pkg.sv
// Shared XGMII receive definitions: control characters, CRC-32 constants,
// receive FSM states and the per-frame error-flag payload.
// Also holds the byte-serial CRC-32 step used by the 64-bit CRC block.
package xgmii_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned CTRL_W = 8;
  localparam int unsigned NLANES = 8;
  localparam int unsigned LEN_W  = 16;

  localparam logic [7:0] XGMII_IDLE  = 8'h07;
  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_TERM  = 8'hFD;
  localparam logic [7:0] XGMII_ERR   = 8'hFE;
  localparam logic [7:0] PREAMBLE    = 8'h55;
  localparam logic [7:0] SFD         = 8'hD5;

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  typedef enum logic {
    IDLE = 1'b0,
    DATA = 1'b1
  } rx_state_e;

  // Per-frame error cause, MSB first: {fcs, len, ctrl, preamble}
  typedef struct packed {
    logic fcs;
    logic len;
    logic ctrl;
    logic pre;
  } err_flags_t;

  // One reflected CRC-32 byte step, bits consumed LSB first
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc ^ {24'd0, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_d64.sv
// Combinational next-CRC over the low nbytes_i lanes of a 64-bit word.
// Lane 0 (bits 7:0) is processed first; nbytes_i = 0 passes crc_i through.
//   crc_i    : current CRC register
//   data_i   : 8 byte lanes
//   nbytes_i : number of valid lanes starting at lane 0 (0..8)
//   crc_c    : CRC after consuming the valid lanes
module crc32_d64
  import xgmii_pkg::*;
(
  input  logic [31:0]       crc_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [3:0]        nbytes_i,
  output logic [31:0]       crc_c
);

  always_comb begin
    crc_c = crc_i;
    for (int unsigned i = 0; i < NLANES; i++) begin
      if (4'(i) < nbytes_i) begin
        crc_c = crc32_byte(crc_c, data_i[8*i +: 8]);
      end
    end
  end

endmodule

// File: rtl/xgmii_rx_frame_checker.sv
// Checks received XGMII frames: preamble/SFD, length, control errors, FCS.
// Results appear two cycles after the closing beat (close capture stage,
// then result register), so a frame may close on every cycle.
//   clk156, sys_rst_n     : clock, async active-low reset
//   xgmii_rxd/xgmii_rxc   : aligned 64-bit RX data and per-lane control
//   clr_cnt               : synchronous counter clear, beats an increment
//   frame_done            : one-cycle result strobe
//   frame_good/frame_len  : last frame verdict and DA..FCS byte count
//   good_cnt/bad_cnt      : wrapping frame counters
//   err_flags             : last frame cause {fcs, len, ctrl, preamble}
module xgmii_rx_frame_checker
  import xgmii_pkg::*;
#(
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1518,
  parameter int unsigned CNT_W   = 32
) (
  input  logic              clk156,
  input  logic              sys_rst_n,
  input  logic [DATA_W-1:0] xgmii_rxd,
  input  logic [CTRL_W-1:0] xgmii_rxc,
  input  logic              clr_cnt,
  output logic              frame_done,
  output logic              frame_good,
  output logic [LEN_W-1:0]  frame_len,
  output logic [CNT_W-1:0]  good_cnt,
  output logic [CNT_W-1:0]  bad_cnt,
  output logic [3:0]        err_flags
);

  localparam int unsigned LEN_SUM_W = LEN_W + 1;

  // Running frame state
  rx_state_e        state_q, state_d;
  logic [31:0]      crc_q, crc_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             pre_err_q, pre_err_d;

  // Captured closing frame (CRC pipeline stage)
  logic             cls_vld_q, cls_vld_d;
  logic [31:0]      cls_crc_q, cls_crc_d;
  logic [LEN_W-1:0] cls_len_q, cls_len_d;
  logic             cls_ctrl_q, cls_ctrl_d;
  logic             cls_pre_q, cls_pre_d;

  // Result register and counters
  logic             done_q, done_d;
  logic             good_q, good_d;
  logic [LEN_W-1:0] res_len_q, res_len_d;
  err_flags_t       res_flags_q, res_flags_d;
  logic [CNT_W-1:0] good_cnt_q, good_cnt_d;
  logic [CNT_W-1:0] bad_cnt_q, bad_cnt_d;

  // Beat decode
  logic                 is_start_c;
  logic                 pre_ok_c;
  logic [3:0]           ctl_lane_c;
  logic [7:0]           ctl_byte_c;
  logic [3:0]           nbytes_c;
  logic [31:0]          crc_upd_c;
  logic [LEN_SUM_W-1:0] len_sum_c;
  logic [LEN_W-1:0]     len_add_c;
  err_flags_t           res_flags_c;

  assign is_start_c = (xgmii_rxc == 8'h01) && (xgmii_rxd[7:0] == XGMII_START);
  assign pre_ok_c   = (xgmii_rxd[63:8] == {SFD, {6{PREAMBLE}}});

  // Lowest control lane; 8 when the whole beat is data
  always_comb begin
    ctl_lane_c = 4'd8;
    for (int i = 7; i >= 0; i--) begin
      if (xgmii_rxc[i]) ctl_lane_c = 4'(i);
    end
  end

  assign ctl_byte_c = xgmii_rxd[{ctl_lane_c[2:0], 3'b000} +: 8];

  // Data lanes precede the first control lane; a start beat carries none
  assign nbytes_c = (state_q == DATA && !is_start_c) ? ctl_lane_c : 4'd0;

  crc32_d64 u_crc (
    .crc_i    (crc_q),
    .data_i   (xgmii_rxd),
    .nbytes_i (nbytes_c),
    .crc_c    (crc_upd_c)
  );

  // Saturating length accumulate
  assign len_sum_c = {1'b0, len_q} + LEN_SUM_W'(nbytes_c);
  assign len_add_c = len_sum_c[LEN_W] ? '1 : len_sum_c[LEN_W-1:0];

  // Receive FSM and close capture
  always_comb begin
    state_d    = state_q;
    crc_d      = crc_q;
    len_d      = len_q;
    pre_err_d  = pre_err_q;
    cls_vld_d  = 1'b0;
    cls_crc_d  = cls_crc_q;
    cls_len_d  = cls_len_q;
    cls_ctrl_d = cls_ctrl_q;
    cls_pre_d  = cls_pre_q;
    case (state_q)
      IDLE: begin
        if (is_start_c) begin
          state_d   = DATA;
          crc_d     = CRC_INIT;
          len_d     = '0;
          pre_err_d = !pre_ok_c;
        end
      end
      DATA: begin
        if (is_start_c) begin
          // Close the interrupted frame as bad and open the new one here
          cls_vld_d  = 1'b1;
          cls_crc_d  = crc_q;
          cls_len_d  = len_q;
          cls_ctrl_d = 1'b1;
          cls_pre_d  = pre_err_q;
          crc_d      = CRC_INIT;
          len_d      = '0;
          pre_err_d  = !pre_ok_c;
        end else begin
          crc_d = crc_upd_c;
          len_d = len_add_c;
          if (xgmii_rxc != '0) begin
            cls_vld_d  = 1'b1;
            cls_crc_d  = crc_upd_c;
            cls_len_d  = len_add_c;
            cls_ctrl_d = (ctl_byte_c != XGMII_TERM);
            cls_pre_d  = pre_err_q;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Verdict of the captured frame and result/counter next state
  always_comb begin
    res_flags_c.fcs  = (cls_crc_q != CRC_RESIDUE);
    res_flags_c.len  = (cls_len_q < LEN_W'(MIN_LEN)) || (cls_len_q > LEN_W'(MAX_LEN));
    res_flags_c.ctrl = cls_ctrl_q;
    res_flags_c.pre  = cls_pre_q;

    done_d      = cls_vld_q;
    good_d      = good_q;
    res_len_d   = res_len_q;
    res_flags_d = res_flags_q;
    good_cnt_d  = good_cnt_q;
    bad_cnt_d   = bad_cnt_q;
    if (cls_vld_q) begin
      good_d      = ~|res_flags_c;
      res_len_d   = cls_len_q;
      res_flags_d = res_flags_c;
      if (|res_flags_c) bad_cnt_d = bad_cnt_q + CNT_W'(1);
      else              good_cnt_d = good_cnt_q + CNT_W'(1);
    end
    if (clr_cnt) begin
      good_cnt_d = '0;
      bad_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk156 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      crc_q       <= CRC_INIT;
      len_q       <= '0;
      pre_err_q   <= 1'b0;
      cls_vld_q   <= 1'b0;
      cls_crc_q   <= '0;
      cls_len_q   <= '0;
      cls_ctrl_q  <= 1'b0;
      cls_pre_q   <= 1'b0;
      done_q      <= 1'b0;
      good_q      <= 1'b0;
      res_len_q   <= '0;
      res_flags_q <= '0;
      good_cnt_q  <= '0;
      bad_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      len_q       <= len_d;
      pre_err_q   <= pre_err_d;
      cls_vld_q   <= cls_vld_d;
      cls_crc_q   <= cls_crc_d;
      cls_len_q   <= cls_len_d;
      cls_ctrl_q  <= cls_ctrl_d;
      cls_pre_q   <= cls_pre_d;
      done_q      <= done_d;
      good_q      <= good_d;
      res_len_q   <= res_len_d;
      res_flags_q <= res_flags_d;
      good_cnt_q  <= good_cnt_d;
      bad_cnt_q   <= bad_cnt_d;
    end
  end

  assign frame_done = done_q;
  assign frame_good = good_q;
  assign frame_len  = res_len_q;
  assign err_flags  = res_flags_q;
  assign good_cnt   = good_cnt_q;
  assign bad_cnt    = bad_cnt_q;

endmodule

// File: tb/tb_xgmii_rx_frame_checker.sv
// Randomized bench for xgmii_rx_frame_checker. Frames are built as byte
// lists, serialized onto a lane stream and packed into beats; expected
// results come from whole-frame rules (byte count, appended FCS versus
// CRC of the body, how the frame was ended).
`timescale 1ns/1ps
module tb_xgmii_rx_frame_checker;

  localparam int unsigned CNT_W = 32;

  logic             clk156 = 1'b0;
  logic             sys_rst_n = 1'b0;
  logic [63:0]      xgmii_rxd = {8{8'h07}};
  logic [7:0]       xgmii_rxc = 8'hFF;
  logic             clr_cnt = 1'b0;
  logic             frame_done, frame_good;
  logic [15:0]      frame_len;
  logic [CNT_W-1:0] good_cnt, bad_cnt;
  logic [3:0]       err_flags;

  xgmii_rx_frame_checker #(.MIN_LEN(64), .MAX_LEN(1518), .CNT_W(CNT_W)) dut (
    .clk156(clk156), .sys_rst_n(sys_rst_n), .xgmii_rxd(xgmii_rxd), .xgmii_rxc(xgmii_rxc),
    .clr_cnt(clr_cnt), .frame_done(frame_done), .frame_good(frame_good), .frame_len(frame_len),
    .good_cnt(good_cnt), .bad_cnt(bad_cnt), .err_flags(err_flags)
  );

  always #5 clk156 = ~clk156;

  typedef logic [7:0] bq_t[$];
  typedef struct { logic [7:0] b; logic c; int res; bit clr_after; } lane_t;
  typedef struct { bit good; logic [15:0] len; logic [3:0] flags; } res_t;
  typedef struct { longint due; res_t r; } exp_t;

  lane_t  lq[$];
  res_t   results[$];
  exp_t   expq[$];
  int     pend_res = -1;
  bit     pend_clr = 1'b0;
  int     n_checks = 0;
  int     n_errors = 0;
  longint cyc = 0;
  bit     clr_at_edge = 1'b0;
  bit     mon_en = 1'b0;
  logic [CNT_W-1:0] exp_good = '0;
  logic [CNT_W-1:0] exp_bad = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference CRC-32 of a byte list: the FCS value as transmitted
  function automatic logic [31:0] ref_crc(input bq_t q);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      c = c ^ {24'd0, q[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic bq_t make_frame(input int len, input bit bcast);
    bq_t q;
    logic [31:0] f;
    for (int i = 0; i < len - 4; i++) q.push_back(8'($urandom));
    if (bcast) begin
      for (int i = 0; i < 6; i++) q[i] = 8'hFF;
      q[12] = 8'h08; q[13] = 8'h00; q[23] = 8'h11;
    end
    f = ref_crc(q);
    for (int i = 0; i < 4; i++) q.push_back(f[8*i +: 8]);
    return q;
  endfunction

  // Expected verdict from the bytes the checker actually received
  function automatic res_t eval_frame(input bq_t d, input bit pre_bad, input bit ctrl);
    res_t r;
    bq_t body;
    logic [31:0] fcs;
    bit fcs_bad, len_bad;
    int n;
    n = d.size();
    r.len = (n > 65535) ? 16'hFFFF : 16'(n);
    fcs_bad = 1'b1;
    if (n >= 4) begin
      for (int i = 0; i < n - 4; i++) body.push_back(d[i]);
      fcs = {d[n-1], d[n-2], d[n-3], d[n-4]};
      fcs_bad = (ref_crc(body) != fcs);
    end
    len_bad = (n < 64) || (n > 1518);
    r.flags = {fcs_bad, len_bad, ctrl, pre_bad};
    r.good = (r.flags == 4'b0000);
    return r;
  endfunction

  function automatic void push_lane(input logic [7:0] b, input logic c, input int res, input bit clr_after);
    lane_t l;
    l.b = b; l.c = c; l.res = res; l.clr_after = clr_after;
    lq.push_back(l);
  endfunction

  function automatic void align();
    while (lq.size() % 8 != 0) push_lane(8'h07, 1'b1, -1, 1'b0);
  endfunction

  function automatic void push_oset();
    align();
    push_lane(8'h9C, 1'b1, -1, 1'b0);
    for (int i = 0; i < 3; i++) push_lane(8'h00, 1'b0, -1, 1'b0);
    for (int i = 0; i < 4; i++) push_lane(8'h07, 1'b1, -1, 1'b0);
  endfunction

  // cut < 0: normal terminate. Otherwise frame ends after 'cut' bytes, by FE
  // or (cut_start, cut multiple of 8) by the start beat of the next frame.
  function automatic void add_frame(input bq_t data, input bit pre_bad, input int cut,
                                    input bit cut_start, input int ifg, input bit clr_after);
    bq_t sent;
    int n, idx;
    align();
    push_lane(8'hFB, 1'b1, pend_res, pend_clr);
    pend_res = -1;
    pend_clr = 1'b0;
    for (int i = 1; i <= 6; i++) push_lane((pre_bad && i == 3) ? 8'h5A : 8'h55, 1'b0, -1, 1'b0);
    push_lane(8'hD5, 1'b0, -1, 1'b0);
    n = (cut < 0) ? data.size() : cut;
    for (int i = 0; i < n; i++) begin
      push_lane(data[i], 1'b0, -1, 1'b0);
      sent.push_back(data[i]);
    end
    results.push_back(eval_frame(sent, pre_bad, cut >= 0));
    idx = results.size() - 1;
    if (cut >= 0 && cut_start) begin
      pend_res = idx;
      pend_clr = clr_after;
    end else begin
      push_lane((cut < 0) ? 8'hFD : 8'hFE, 1'b1, idx, clr_after);
      for (int i = 0; i < ifg; i++) push_lane(8'h07, 1'b1, -1, 1'b0);
    end
  endfunction

  task automatic drive_idle(input bit clr);
    @(posedge clk156);
    #1;
    xgmii_rxd = {8{8'h07}};
    xgmii_rxc = 8'hFF;
    clr_cnt = clr;
  endtask

  // Pack the lane stream into beats, drive them, then drain results
  task automatic run_stream();
    logic [63:0] d;
    logic [7:0]  c;
    int          res;
    bit          clr_next, clr_now;
    lane_t       l;
    exp_t        e;
    int          w;
    clr_next = 1'b0;
    align();
    while (lq.size() > 0) begin
      res = -1;
      clr_now = clr_next;
      clr_next = 1'b0;
      for (int k = 0; k < 8; k++) begin
        l = lq.pop_front();
        d[8*k +: 8] = l.b;
        c[k] = l.c;
        if (l.res >= 0) res = l.res;
        if (l.clr_after) clr_next = 1'b1;
      end
      @(posedge clk156);
      #1;
      xgmii_rxd = d;
      xgmii_rxc = c;
      clr_cnt = clr_now;
      if (res >= 0) begin
        e.due = cyc + 2;
        e.r = results[res];
        expq.push_back(e);
      end
    end
    w = 0;
    while (expq.size() > 0 && w < 12) begin
      drive_idle(clr_next);
      clr_next = 1'b0;
      w++;
    end
    if (expq.size() > 0) begin
      check_eq("drain_timeout", 64'(expq.size()), 64'd0);
      expq.delete();
    end
    drive_idle(clr_next);
    drive_idle(1'b0);
  endtask

  always @(posedge clk156) begin
    cyc <= cyc + 1;
    clr_at_edge <= clr_cnt;
  end

  // Result monitor: every expected result at its due cycle, nothing else
  always @(negedge clk156) begin : mon
    exp_t e;
    if (sys_rst_n && mon_en) begin
      while (expq.size() > 0 && expq[0].due < cyc) begin
        check_eq("done_timing", 64'(cyc), 64'(expq[0].due));
        void'(expq.pop_front());
      end
      if (expq.size() > 0 && expq[0].due == cyc) begin
        e = expq.pop_front();
        check_eq("frame_done", 64'(frame_done), 64'd1);
        check_eq("frame_good", 64'(frame_good), 64'(e.r.good));
        check_eq("frame_len", 64'(frame_len), 64'(e.r.len));
        check_eq("err_flags", 64'(err_flags), 64'(e.r.flags));
        if (clr_at_edge) begin
          exp_good = '0;
          exp_bad = '0;
        end else if (e.r.good) exp_good = exp_good + 1;
        else exp_bad = exp_bad + 1;
        check_eq("good_cnt", 64'(good_cnt), 64'(exp_good));
        check_eq("bad_cnt", 64'(bad_cnt), 64'(exp_bad));
      end else begin
        if (frame_done) check_eq("spurious_done", 64'(frame_done), 64'd0);
        if (clr_at_edge) begin
          exp_good = '0;
          exp_bad = '0;
          check_eq("clr_good_cnt", 64'(good_cnt), 64'd0);
          check_eq("clr_bad_cnt", 64'(bad_cnt), 64'd0);
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_done"}, 64'(frame_done), 64'd0);
    check_eq({tag, "_good"}, 64'(frame_good), 64'd0);
    check_eq({tag, "_len"}, 64'(frame_len), 64'd0);
    check_eq({tag, "_flags"}, 64'(err_flags), 64'd0);
    check_eq({tag, "_good_cnt"}, 64'(good_cnt), 64'd0);
    check_eq({tag, "_bad_cnt"}, 64'(bad_cnt), 64'd0);
  endtask

  initial begin
    bq_t f;
    int mode, len, cut;

    repeat (3) @(posedge clk156);
    @(negedge clk156);
    check_all_zero("reset");
    @(posedge clk156);
    #1;
    sys_rst_n = 1'b1;
    mon_en = 1'b1;

    // Minimum broadcast frame, terminate in lane 0
    f = make_frame(64, 1'b1);
    add_frame(f, 1'b0, -1, 1'b0, 12, 1'b0);
    run_stream();
    check_eq("t1_good_cnt", 64'(good_cnt), 64'd1);
    check_eq("t1_len", 64'(frame_len), 64'd64);
    check_eq("t1_good", 64'(frame_good), 64'd1);

    // Single FCS bit flipped
    f = make_frame(64, 1'b1);
    f[62] = f[62] ^ 8'h10;
    add_frame(f, 1'b0, -1, 1'b0, 12, 1'b0);
    run_stream();
    check_eq("t2_flags", 64'(err_flags), 64'b1000);
    check_eq("t2_bad_cnt", 64'(bad_cnt), 64'd1);
    check_eq("t2_good_cnt", 64'(good_cnt), 64'd1);

    // Terminate swept through every lane, short gaps
    for (int l = 64; l <= 71; l++) begin
      f = make_frame(l, 1'b0);
      add_frame(f, 1'b0, -1, 1'b0, $urandom_range(0, 12), 1'b0);
    end
    run_stream();
    check_eq("t3_good_cnt", 64'(good_cnt), 64'd9);
    check_eq("t3_last_len", 64'(frame_len), 64'd71);

    // Runt then giant, both with valid FCS
    f = make_frame(60, 1'b0);
    add_frame(f, 1'b0, -1, 1'b0, 12, 1'b0);
    run_stream();
    check_eq("t4_runt_flags", 64'(err_flags), 64'b0100);
    f = make_frame(1519, 1'b0);
    add_frame(f, 1'b0, -1, 1'b0, 12, 1'b0);
    run_stream();
    check_eq("t4_giant_flags", 64'(err_flags), 64'b0100);
    check_eq("t4_bad_cnt", 64'(bad_cnt), 64'd3);

    // FE in lane 3, start beat mid-frame, back-to-back start beats, ordered set, bad preamble
    f = make_frame(100, 1'b0);
    add_frame(f, 1'b0, 19, 1'b0, 12, 1'b0);
    f = make_frame(200, 1'b0);
    add_frame(f, 1'b0, 32, 1'b1, 0, 1'b0);
    f = make_frame(64, 1'b0);
    add_frame(f, 1'b0, 0, 1'b1, 0, 1'b0);
    f = make_frame(64, 1'b0);
    add_frame(f, 1'b0, 0, 1'b1, 0, 1'b0);
    f = make_frame(64, 1'b0);
    add_frame(f, 1'b0, -1, 1'b0, 12, 1'b0);
    push_oset();
    f = make_frame(80, 1'b0);
    add_frame(f, 1'b1, -1, 1'b0, 12, 1'b0);
    run_stream();
    check_eq("t5_good_cnt", 64'(good_cnt), 64'd10);
    check_eq("t5_pre_flags", 64'(err_flags), 64'b0001);

    // Random mix of lengths and faults
    for (int n = 0; n < 30; n++) begin
      mode = (n == 29) ? 0 : int'($urandom_range(0, 4));
      len = int'($urandom_range(40, 1530));
      f = make_frame(len, 1'b0);
      if (pend_res < 0 && $urandom_range(0, 3) == 0) push_oset();
      case (mode)
        1: begin
          cut = int'($urandom_range(0, len - 1));
          f[cut] = f[cut] ^ 8'(1 << $urandom_range(0, 7));
          add_frame(f, 1'b0, -1, 1'b0, $urandom_range(0, 15), 1'b0);
        end
        2: add_frame(f, 1'b1, -1, 1'b0, $urandom_range(0, 15), 1'b0);
        3: add_frame(f, 1'b0, int'($urandom_range(4, len - 1)), 1'b0, $urandom_range(0, 15), 1'b0);
        4: add_frame(f, 1'b0, 8 * int'($urandom_range(0, (len - 1) / 8)), 1'b1, 0, 1'b0);
        default: add_frame(f, 1'b0, -1, 1'b0, $urandom_range(0, 15), 1'b0);
      endcase
    end
    run_stream();

    // 100 back-to-back minimum frames, counters cleared with result #50
    for (int n = 1; n <= 100; n++) begin
      f = make_frame(64, 1'b0);
      add_frame(f, 1'b0, -1, 1'b0, 12, n == 50);
    end
    run_stream();
    check_eq("t6_good_cnt", 64'(good_cnt), 64'd50);
    check_eq("t6_bad_cnt", 64'(bad_cnt), 64'd0);

    // Reset in the middle of a frame; the tail arrives while in reset
    @(posedge clk156);
    #1;
    xgmii_rxd = {8'hD5, {6{8'h55}}, 8'hFB};
    xgmii_rxc = 8'h01;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk156);
      #1;
      xgmii_rxd = {$urandom, $urandom};
      xgmii_rxc = 8'h00;
    end
    #2;
    mon_en = 1'b0;
    sys_rst_n = 1'b0;
    expq.delete();
    exp_good = '0;
    exp_bad = '0;
    #1;
    check_all_zero("rst_mid");
    @(posedge clk156);
    #1;
    xgmii_rxd = {{7{8'h07}}, 8'hFD};
    xgmii_rxc = 8'hFF;
    @(posedge clk156);
    #1;
    sys_rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (10) drive_idle(1'b0);
    check_all_zero("rst_after");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
